// File: rtl/rsa_pkg.sv
// Shared types for the modular-exponentiation sequencer and its per-multiply sub-sequencer.
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_SCAN, ST_SQ, ST_MUL, ST_POST, ST_FIX, ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        PH_IDLE, PH_CLR, PH_LOAD, PH_RUN, PH_LDR, PH_CAP
    } phase_t;

    typedef enum logic [2:0] {
        OP_NONE, P_R2, X_X, X_PBAR, X_ONE
    } opsel_t;

    function automatic opsel_t op_sel(input state_t st);
        opsel_t s;
        s = OP_NONE;
        case (st)
            ST_PRE:  s = P_R2;
            ST_SQ:   s = X_X;
            ST_MUL:  s = X_PBAR;
            ST_POST: s = X_ONE;
            default: s = OP_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mmm_seq.sv
// Single Montgomery-multiply sequencer: CLR, LOAD, RUN x MMM_CYCLES, LDR, CAP.
// state   | meaning
// PH_IDLE | no multiply in flight
// PH_CLR  | multiplier held in reset
// PH_LOAD | operands loaded, first enable
// PH_RUN  | enable held while the down-counter runs to zero
// PH_LDR  | multiplier result register loaded
// PH_CAP  | result valid on mmm_r; a new go chains straight into CLR
module mmm_seq
    import rsa_pkg::*;
#(
    parameter int MMM_CYCLES = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic cap,
    output logic idle,
    output logic mmm_en,
    output logic mmm_rst_n,
    output logic mmm_ld_a,
    output logic mmm_ld_r
);

    localparam int CW = $clog2(MMM_CYCLES + 1);

    phase_t phase, phase_nx;
    logic [CW-1:0] cnt, cnt_nx;

    assign cap  = (phase == PH_CAP);
    assign idle = (phase == PH_IDLE);

    always_comb begin
        phase_nx = phase;
        cnt_nx   = cnt;
        case (phase)
            PH_IDLE: if (go) phase_nx = PH_CLR;
            PH_CLR:  phase_nx = PH_LOAD;
            PH_LOAD: begin
                phase_nx = PH_RUN;
                cnt_nx   = CW'(MMM_CYCLES - 1);
            end
            PH_RUN: begin
                if (cnt == '0) phase_nx = PH_LDR;
                else           cnt_nx   = cnt - CW'(1);
            end
            PH_LDR:  phase_nx = PH_CAP;
            PH_CAP:  phase_nx = go ? PH_CLR : PH_IDLE;
            default: phase_nx = PH_IDLE;
        endcase
    end

    // Strobes are registered from the next phase so they line up with the phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= PH_IDLE;
            cnt       <= '0;
            mmm_en    <= 1'b0;
            mmm_rst_n <= 1'b0;
            mmm_ld_a  <= 1'b0;
            mmm_ld_r  <= 1'b0;
        end else begin
            phase     <= phase_nx;
            cnt       <= cnt_nx;
            mmm_en    <= (phase_nx == PH_LOAD) || (phase_nx == PH_RUN);
            mmm_rst_n <= (phase_nx != PH_CLR);
            mmm_ld_a  <= (phase_nx == PH_LOAD);
            mmm_ld_r  <= (phase_nx == PH_LDR);
        end
    end

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer in the Montgomery domain, driving one multiplier.
// Define RSA_EXP_SKIP_LZ_EN to skip leading zero exponent bits (not constant-time).
// state   | meaning
// ST_IDLE | waiting for start, operands latched on accept
// ST_PRE  | Pbar = MMM(P, r2_mod)
// ST_SCAN | skip leading zero exponent bits (skip build only)
// ST_SQ   | X = MMM(X, X)
// ST_MUL  | X = MMM(X, Pbar)
// ST_POST | X = MMM(X, 1), leave the Montgomery domain
// ST_FIX  | final conditional subtract of M
// ST_DONE | one cycle before the done pulse
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MMM_CYCLES = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] plain,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] r_mod,
    input  logic [WIDTH-1:0] r2_mod,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             mmm_en,
    output logic             mmm_rst_n,
    output logic             mmm_ld_a,
    output logic             mmm_ld_r,
    output logic             mmm_lock,
    output logic [WIDTH-1:0] mmm_a,
    output logic [WIDTH-1:0] mmm_b,
    output logic [WIDTH-1:0] mmm_m,
    input  logic [WIDTH-1:0] mmm_r
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t state, state_nx;
    logic [WIDTH-1:0] p_q, e_q, m_q, r1_q, r2_q, pbar_q, x_q;
    logic [WIDTH-1:0] p_nx, e_nx, m_nx, r1_nx, r2_nx, pbar_nx, x_nx, result_nx;
    logic [WIDTH-1:0] a_nx, b_nx, x_fix;
    logic [IW-1:0]    idx, idx_nx, idx_dn;
    logic             go, cap, seq_idle;

    mmm_seq #(.MMM_CYCLES(MMM_CYCLES)) u_seq (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .cap       (cap),
        .idle      (seq_idle),
        .mmm_en    (mmm_en),
        .mmm_rst_n (mmm_rst_n),
        .mmm_ld_a  (mmm_ld_a),
        .mmm_ld_r  (mmm_ld_r)
    );

    assign idx_dn = idx - IW'(1);
    assign x_fix  = (x_q >= m_q) ? (x_q - m_q) : x_q;

    // go is raised on the capture cycle of one multiply so the next CLR follows with no gap.
    always_comb begin
        state_nx  = state;
        go        = 1'b0;
        p_nx      = p_q;
        e_nx      = e_q;
        m_nx      = m_q;
        r1_nx     = r1_q;
        r2_nx     = r2_q;
        pbar_nx   = pbar_q;
        x_nx      = x_q;
        result_nx = result;
        idx_nx    = idx;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    p_nx     = plain;
                    e_nx     = exponent;
                    m_nx     = modulus;
                    r1_nx    = r_mod;
                    r2_nx    = r2_mod;
                    state_nx = ST_PRE;
                end
            end
            ST_PRE: begin
                if (seq_idle) go = 1'b1;
                if (cap) begin
                    pbar_nx = mmm_r;
                    x_nx    = r1_q;
                    idx_nx  = IW'(WIDTH - 1);
`ifdef RSA_EXP_SKIP_LZ_EN
                    if (e_q == '0) begin
                        state_nx = ST_POST;
                        go       = 1'b1;
                    end else if (e_q[WIDTH-1]) begin
                        state_nx = ST_SQ;
                        go       = 1'b1;
                    end else begin
                        state_nx = ST_SCAN;
                    end
`else
                    state_nx = ST_SQ;
                    go       = 1'b1;
`endif
                end
            end
            ST_SCAN: begin
`ifdef RSA_EXP_SKIP_LZ_EN
                idx_nx = idx_dn;
                if (e_q[idx_dn]) begin
                    state_nx = ST_SQ;
                    go       = 1'b1;
                end
`else
                state_nx = ST_SQ;
                go       = 1'b1;
`endif
            end
            ST_SQ: begin
                if (cap) begin
                    x_nx = mmm_r;
                    go   = 1'b1;
                    if (e_q[idx])          state_nx = ST_MUL;
                    else if (idx == '0)    state_nx = ST_POST;
                    else                   idx_nx   = idx_dn;
                end
            end
            ST_MUL: begin
                if (cap) begin
                    x_nx = mmm_r;
                    go   = 1'b1;
                    if (idx == '0) begin
                        state_nx = ST_POST;
                    end else begin
                        idx_nx   = idx_dn;
                        state_nx = ST_SQ;
                    end
                end
            end
            ST_POST: begin
                if (cap) begin
                    x_nx     = mmm_r;
                    state_nx = ST_FIX;
                end
            end
            ST_FIX: begin
                result_nx = x_fix;
                state_nx  = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operands follow the next state so they are already stable when CLR begins.
    always_comb begin
        a_nx = '0;
        b_nx = '0;
        case (op_sel(state_nx))
            P_R2:   begin a_nx = p_nx; b_nx = r2_nx;     end
            X_X:    begin a_nx = x_nx; b_nx = x_nx;      end
            X_PBAR: begin a_nx = x_nx; b_nx = pbar_nx;   end
            X_ONE:  begin a_nx = x_nx; b_nx = WIDTH'(1); end
            default: begin a_nx = '0; b_nx = '0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            p_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            r1_q     <= '0;
            r2_q     <= '0;
            pbar_q   <= '0;
            x_q      <= '0;
            idx      <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mmm_lock <= 1'b0;
            mmm_a    <= '0;
            mmm_b    <= '0;
            mmm_m    <= '0;
        end else begin
            state    <= state_nx;
            p_q      <= p_nx;
            e_q      <= e_nx;
            m_q      <= m_nx;
            r1_q     <= r1_nx;
            r2_q     <= r2_nx;
            pbar_q   <= pbar_nx;
            x_q      <= x_nx;
            idx      <= idx_nx;
            result   <= result_nx;
            busy     <= (state_nx != ST_IDLE);
            done     <= (state == ST_DONE);
            mmm_lock <= (state_nx == ST_IDLE) || (state_nx == ST_DONE);
            mmm_a    <= a_nx;
            mmm_b    <= b_nx;
            mmm_m    <= m_nx;
        end
    end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Scoreboard bench for rsa_exp_ctrl with a behavioural Montgomery multiplier on the mmm_* port.
module tb_rsa_exp_ctrl;

    localparam int W   = 8;
    localparam int MC  = 9;
    localparam int T   = MC + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] plain = '0, exponent = '0, modulus = '0, r_mod = '0, r2_mod = '0;
    logic       busy, done, mmm_en, mmm_rst_n, mmm_ld_a, mmm_ld_r, mmm_lock;
    logic [7:0] result, mmm_a, mmm_b, mmm_m;
    logic [7:0] mmm_r = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int res;
        int lat;
        int mults;
    } exp_t;
    exp_t exp_q[$];

    rsa_exp_ctrl #(.WIDTH(W), .MMM_CYCLES(MC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .plain     (plain),
        .exponent  (exponent),
        .modulus   (modulus),
        .r_mod     (r_mod),
        .r2_mod    (r2_mod),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .mmm_en    (mmm_en),
        .mmm_rst_n (mmm_rst_n),
        .mmm_ld_a  (mmm_ld_a),
        .mmm_ld_r  (mmm_ld_r),
        .mmm_lock  (mmm_lock),
        .mmm_a     (mmm_a),
        .mmm_b     (mmm_b),
        .mmm_m     (mmm_m),
        .mmm_r     (mmm_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // a*b*2^-8 mod m, sometimes returned as the unreduced value +m (< 2m)
    function automatic logic [7:0] mmm_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] m);
        int r;
        r = 0;
        if (m == 8'd0) return 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) r += int'(b);
            if (r[0]) r += int'(m);
            r = r >> 1;
        end
        r = r % int'(m);
        if (a[0] ^ b[0]) r += int'(m);
        return 8'(r);
    endfunction

    task automatic calc(input int e, output int mults, output int lat);
        int n, k, extra;
        k = 0;
        extra = 0;
`ifdef RSA_EXP_SKIP_LZ_EN
        n = 0;
        for (int i = 0; i < W; i++) if (e[i]) n = i + 1;
        if (n != 0) extra = W - n;
`else
        n = W;
`endif
        for (int i = 0; i < n; i++) if (e[i]) k++;
        mults = (n == 0) ? 2 : 2 + n + k;
        lat   = mults * T + 3 + extra;
    endtask

    // Monitor: multiplier model, per-multiply protocol checks, done-time scoreboard pop.
    logic       busy_d = 1'b0;
    bit         in_run = 0, trk = 0, stable = 0, gap = 0;
    int         lat_cnt = 0, mult_cnt = 0, lda_cnt = 0, en_cnt = 0;
    logic [7:0] a0 = '0, b0 = '0, la = '0, lb = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_run = 0;
            trk    = 0;
            busy_d = 1'b0;
        end else begin
            if (busy && !busy_d) begin
                in_run   = 1;
                lat_cnt  = 0;
                mult_cnt = 0;
            end else if (in_run) begin
                lat_cnt++;
            end
            busy_d = busy;

            if (!mmm_rst_n) begin
                trk     = 1;
                a0      = mmm_a;
                b0      = mmm_b;
                stable  = 1;
                gap     = 0;
                lda_cnt = 0;
                en_cnt  = 0;
            end else begin
                if (trk && (mmm_a != a0 || mmm_b != b0)) stable = 0;
                if (mmm_ld_a) begin
                    lda_cnt++;
                    la = mmm_a;
                    lb = mmm_b;
                end
                if (mmm_en) en_cnt++;
                else if (en_cnt > 0 && !mmm_ld_r) gap = 1;
                if (mmm_ld_r) begin
                    chk("ld_r_after_clr", int'(trk), 1);
                    chk("ld_a_per_multiply", lda_cnt, 1);
                    chk("en_consecutive_cycles", gap ? 0 : en_cnt, MC + 1);
                    chk("operands_stable", int'(stable), 1);
                    mmm_r = mmm_model(la, lb, mmm_m);
                    mult_cnt++;
                    trk = 0;
                end
            end

            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", int'(result), e.res);
                    chk("latency", lat_cnt, e.lat);
                    chk("multiply_count", mult_cnt, e.mults);
                end
                in_run = 0;
            end
        end
    end

    // Called at #1 after a rising edge; start is sampled on the next edge.
    task automatic issue(input int p, input int e, input int m, input int r1, input int r2,
                         input int res);
        exp_t x;
        int nm, lt;
        calc(e, nm, lt);
        x.res   = res;
        x.lat   = lt;
        x.mults = nm;
        exp_q.push_back(x);
        plain    = 8'(p);
        exponent = 8'(e);
        modulus  = 8'(m);
        r_mod    = 8'(r1);
        r2_mod   = 8'(r2);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        chk("done_within_budget", int'(seen), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_mmm_en", int'(mmm_en), 0);
        chk("rst_mmm_ld_a", int'(mmm_ld_a), 0);
        chk("rst_mmm_ld_r", int'(mmm_ld_r), 0);
        chk("rst_mmm_lock", int'(mmm_lock), 0);
        chk("rst_mmm_rst_n", int'(mmm_rst_n), 0);
        chk("rst_mmm_abm", int'(mmm_a) + int'(mmm_b) + int'(mmm_m), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_mmm_rst_n", int'(mmm_rst_n), 1);
        chk("idle_mmm_lock", int'(mmm_lock), 1);
        chk("idle_busy", int'(busy), 0);

        // 5^3 mod 13 = 8
        issue(5, 3, 13, 9, 3, 8);
        wait_done();
        // E = 0 gives the Montgomery one reduced: 1
        issue(7, 0, 13, 9, 3, 1);
        wait_done();
        // 2^255 mod 59: 2^29 = -1 mod 59, so 2^255 = 2^23 = 47
        issue(2, 8'hFF, 59, 20, 46, 47);
        wait_done();
        // 4^13 mod 11: 4^5 = 1 mod 11, so 4^3 = 64 mod 11 = 9
        issue(4, 8'h0D, 11, 3, 9, 9);
        wait_done();
        // M = 1 collapses everything to 0
        issue(0, 0, 1, 0, 0, 0);
        wait_done();

        // Start while busy is dropped; next start lands on the cycle done is seen.
        issue(5, 3, 13, 9, 3, 8);
        repeat (19) @(posedge clk);
        #1;
        plain = 8'd2; exponent = 8'hFF; modulus = 8'd59; r_mod = 8'd20; r2_mod = 8'd46;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_during_run", int'(busy), 1);
        wait_done();
        issue(7, 0, 13, 9, 3, 1);
        wait_done();

        // Reset taken on cycle 40 of a run aborts it without a done.
        issue(5, 3, 13, 9, 3, 8);
        repeat (38) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_mmm_rst_n", int'(mmm_rst_n), 0);
        chk("abort_mmm_m", int'(mmm_m), 0);
        chk("abort_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(5, 3, 13, 9, 3, 8);
        wait_done();

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
